// File: rtl/rf_seq_pkg.sv
// Shared definitions for the register-file sequencer: opcodes, FSM states
// and instruction field positions.
package rf_seq_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_MOV  = 4'd6;
  localparam logic [3:0] OP_LDI  = 4'd7;
  localparam logic [3:0] OP_SHL1 = 4'd8;
  localparam logic [3:0] OP_SHR1 = 4'd9;

  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 9;
  localparam int unsigned RS1_MSB = 8;
  localparam int unsigned RS1_LSB = 6;
  localparam int unsigned RS2_MSB = 5;
  localparam int unsigned RS2_LSB = 3;
  localparam int unsigned IMM_MSB = 8;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/rf_alu16.sv
// Combinational 16-bit ALU for the sequencer; reports whether the opcode
// writes back, whether it updates carry, and whether it is illegal.
module rf_alu16
  import rf_seq_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic [8:0]  imm,
  output logic [15:0] result,
  output logic        carry,
  output logic        carry_valid,
  output logic        writes,
  output logic        illegal
);

  logic [16:0] sum;

  assign sum = {1'b0, op_a} + {1'b0, op_b};

  always_comb begin
    result      = '0;
    carry       = 1'b0;
    carry_valid = 1'b0;
    writes      = 1'b1;
    illegal     = 1'b0;
    case (opcode)
      OP_NOP:  writes = 1'b0;
      OP_ADD:  begin
        result      = sum[15:0];
        carry       = sum[16];
        carry_valid = 1'b1;
      end
      OP_SUB:  begin
        result      = op_a - op_b;
        carry       = (op_a < op_b);
        carry_valid = 1'b1;
      end
      OP_AND:  result = op_a & op_b;
      OP_OR:   result = op_a | op_b;
      OP_XOR:  result = op_a ^ op_b;
      OP_MOV:  result = op_a;
      OP_LDI:  result = {7'd0, imm};
      OP_SHL1: begin
        result      = {op_a[14:0], 1'b0};
        carry       = op_a[15];
        carry_valid = 1'b1;
      end
      OP_SHR1: begin
        result      = {1'b0, op_a[15:1]};
        carry       = op_a[0];
        carry_valid = 1'b1;
      end
      default: begin
        writes  = 1'b0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/rf_seq_ctrl.sv
// Register-file sequencer: accepts one instruction, reads operands, executes
// in rf_alu16 and writes back, pulsing done (and err for illegal opcodes).
module rf_seq_ctrl
  import rf_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] instr,
  output logic [2:0]  rf_rd_addr_a,
  output logic [2:0]  rf_rd_addr_b,
  output logic [2:0]  rf_wr_addr,
  output logic        rf_wr,
  output logic [15:0] rf_d_in,
  input  logic [15:0] rf_d_out_a,
  input  logic [15:0] rf_d_out_b,
  output logic        done,
  output logic        err,
  output logic        flag_z,
  output logic        flag_c
);

  state_t      state;
  logic [15:0] ir;
  logic [15:0] op_a;
  logic [15:0] op_b;

  logic [15:0] alu_result;
  logic        alu_carry;
  logic        alu_carry_valid;
  logic        alu_writes;
  logic        alu_illegal;

  rf_alu16 u_alu (
    .opcode      (ir[OP_MSB:OP_LSB]),
    .op_a        (op_a),
    .op_b        (op_b),
    .imm         (ir[IMM_MSB:IMM_LSB]),
    .result      (alu_result),
    .carry       (alu_carry),
    .carry_valid (alu_carry_valid),
    .writes      (alu_writes),
    .illegal     (alu_illegal)
  );

  assign in_ready = (state == IDLE) && !reset;

  // Read addresses are loaded straight from instr on accept so they are
  // already valid throughout READ.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ir           <= '0;
      op_a         <= '0;
      op_b         <= '0;
      rf_rd_addr_a <= '0;
      rf_rd_addr_b <= '0;
      rf_wr_addr   <= '0;
      rf_d_in      <= '0;
      rf_wr        <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      flag_z       <= 1'b0;
      flag_c       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ir           <= instr;
            rf_rd_addr_a <= instr[RS1_MSB:RS1_LSB];
            rf_rd_addr_b <= instr[RS2_MSB:RS2_LSB];
            state        <= READ;
          end
        end
        READ: begin
          op_a  <= rf_d_out_a;
          op_b  <= rf_d_out_b;
          state <= EXEC;
        end
        EXEC: begin
          if (alu_writes) begin
            rf_wr      <= 1'b1;
            rf_wr_addr <= ir[RD_MSB:RD_LSB];
            rf_d_in    <= alu_result;
            flag_z     <= (alu_result == 16'd0);
          end
          if (alu_carry_valid) begin
            flag_c <= alu_carry;
          end
          done  <= 1'b1;
          err   <= alu_illegal;
          state <= WRITE;
        end
        WRITE: begin
          rf_wr <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_seq_ctrl.sv
// End-to-end bench: rf_seq_ctrl driving an 8x16 register file, checked
// against a scoreboard of expected write-back/flag results.
module tb_rf_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic [2:0]  rf_rd_addr_a;
  logic [2:0]  rf_rd_addr_b;
  logic [2:0]  rf_wr_addr;
  logic        rf_wr;
  logic [15:0] rf_d_in;
  logic [15:0] rf_d_out_a;
  logic [15:0] rf_d_out_b;
  logic        done;
  logic        err;
  logic        flag_z;
  logic        flag_c;

  always #5 clk = ~clk;

  rf_seq_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .instr        (instr),
    .rf_rd_addr_a (rf_rd_addr_a),
    .rf_rd_addr_b (rf_rd_addr_b),
    .rf_wr_addr   (rf_wr_addr),
    .rf_wr        (rf_wr),
    .rf_d_in      (rf_d_in),
    .rf_d_out_a   (rf_d_out_a),
    .rf_d_out_b   (rf_d_out_b),
    .done         (done),
    .err          (err),
    .flag_z       (flag_z),
    .flag_c       (flag_c)
  );

  // Register file: combinational reads, clocked write; contents kept over
  // reset so an abandoned write is observable.
  logic [15:0] rf [8] = '{default: 16'h0000};
  assign rf_d_out_a = rf[rf_rd_addr_a];
  assign rf_d_out_b = rf[rf_rd_addr_b];
  always @(posedge clk) if (rf_wr) rf[rf_wr_addr] <= rf_d_in;

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] data;
    logic        err;
    logic        z;
    logic        c;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model_rf [8] = '{default: 16'h0000};
  logic        mz = 1'b0;
  logic        mc = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit acc_valid = 0;
  bit held_mode = 0;
  int held_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] rr(input logic [3:0] op, input int unsigned rd,
                                     input int unsigned rs1, input int unsigned rs2);
    return {op, rd[2:0], rs1[2:0], rs2[2:0], 3'b000};
  endfunction

  function automatic logic [15:0] ldi(input int unsigned rd, input int unsigned imm);
    return {4'd7, rd[2:0], imm[8:0]};
  endfunction

  task automatic push_exp(input logic [15:0] ins);
    exp_t        e;
    logic [3:0]  op;
    logic [15:0] a, b, r;
    logic [16:0] s;
    logic        c, cv, wr;
    op = ins[15:12];
    a  = model_rf[ins[8:6]];
    b  = model_rf[ins[5:3]];
    r = 16'h0; c = 1'b0; cv = 1'b0; wr = 1'b1;
    case (op)
      4'd1: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16]; cv = 1'b1; end
      4'd2: begin r = a - b; c = (a < b); cv = 1'b1; end
      4'd3: r = a & b;
      4'd4: r = a | b;
      4'd5: r = a ^ b;
      4'd6: r = a;
      4'd7: r = {7'd0, ins[8:0]};
      4'd8: begin r = a << 1; c = a[15]; cv = 1'b1; end
      4'd9: begin r = a >> 1; c = a[0]; cv = 1'b1; end
      default: wr = 1'b0;
    endcase
    if (wr) begin
      model_rf[ins[11:9]] = r;
      mz = (r == 16'h0);
    end
    if (cv) mc = c;
    e.wr   = wr;
    e.addr = ins[11:9];
    e.data = r;
    e.err  = (op >= 4'd10);
    e.z    = mz;
    e.c    = mc;
    sb.push_back(e);
  endtask

  // Drive one instruction; called at posedge+#1 and returns at posedge+#1 after accept.
  task automatic issue(input logic [15:0] ins, input bit expect_it, input bit hold);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    instr    = ins;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    if (ok && expect_it) push_exp(ins);
    if (!hold) in_valid = 1'b0;
  endtask

  // Output monitor: pops the scoreboard on every done pulse.
  initial begin
    exp_t e;
    int   idx;
    forever begin
      @(negedge clk);
      idx = 0;
      if (reset) begin
        chk("rst_ready", in_ready, 0);
        acc_valid = 0;
      end else begin
        if (acc_valid) begin
          idx = cyc - acc_cyc + 1;
          if (idx >= 1 && idx <= 3) chk("busy_ready", in_ready, 0);
        end
        if (done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", done, 0);
          end else begin
            e = sb.pop_front();
            chk("latency", idx, 3);
            chk("wr", rf_wr, e.wr);
            chk("err", err, e.err);
            chk("flag_z", flag_z, e.z);
            chk("flag_c", flag_c, e.c);
            if (e.wr) begin
              chk("wr_addr", rf_wr_addr, e.addr);
              chk("wr_data", rf_d_in, e.data);
            end
          end
        end else begin
          chk("stray_wr", rf_wr, 0);
          chk("stray_err", err, 0);
        end
        if (in_valid && in_ready) begin
          if (held_mode) begin
            if (held_cnt > 0) chk("accept_gap", cyc + 1 - acc_cyc, 4);
            held_cnt++;
          end
          acc_cyc   = cyc + 1;
          acc_valid = 1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] prog[$];
    reset    = 1'b1;
    in_valid = 1'b0;
    instr    = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rf_wr", rf_wr, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_flag_z", flag_z, 0);
    chk("rst_flag_c", flag_c, 0);
    chk("rst_addr_a", rf_rd_addr_a, 0);
    chk("rst_addr_b", rf_rd_addr_b, 0);
    chk("rst_wr_addr", rf_wr_addr, 0);
    chk("rst_d_in", rf_d_in, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    prog.push_back(ldi(1, 9'h0FF));
    prog.push_back(ldi(2, 9'h001));
    prog.push_back(rr(4'd6, 3, 1, 0));   // MOV r3,r1 -> 00FF
    prog.push_back(ldi(1, 9'h000));
    prog.push_back(rr(4'd2, 1, 1, 2));   // SUB r1 -> FFFF
    prog.push_back(rr(4'd1, 3, 1, 2));   // ADD -> 0000, z=1 c=1
    prog.push_back(ldi(1, 9'h001));
    prog.push_back(ldi(2, 9'h002));
    prog.push_back(rr(4'd2, 4, 1, 2));   // SUB -> FFFF borrow
    prog.push_back(rr(4'd3, 5, 4, 4));   // AND keeps carry
    prog.push_back(rr(4'hC, 6, 1, 2));   // illegal
    prog.push_back(rr(4'd0, 7, 1, 2));   // NOP
    prog.push_back(rr(4'd8, 6, 4, 0));   // SHL1 FFFF -> FFFE c=1
    prog.push_back(rr(4'd9, 7, 1, 0));   // SHR1 1 -> 0 c=1 z=1
    prog.push_back(rr(4'd5, 0, 4, 2));   // XOR
    prog.push_back(rr(4'd4, 2, 1, 3));   // OR
    foreach (prog[i]) issue(prog[i], 1, 0);

    held_mode = 1;
    issue(rr(4'd1, 7, 1, 2), 1, 1);
    issue(rr(4'd1, 7, 7, 2), 1, 1);
    issue(rr(4'd1, 7, 7, 7), 1, 0);
    repeat (5) @(posedge clk);
    #1;
    held_mode = 0;

    issue(ldi(6, 9'h055), 1, 0);
    issue(rr(4'd1, 6, 1, 2), 0, 0);      // aborted during EXEC
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    mz = 1'b0;
    mc = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_flag_z", flag_z, 0);
    chk("post_rst_flag_c", flag_c, 0);
    chk("post_rst_done", done, 0);
    @(posedge clk);
    #1;
    issue(rr(4'd6, 0, 6, 0), 1, 0);      // MOV r0,r6 after recovery

    for (int i = 0; i < 50; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", sb.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) chk($sformatf("rf_r%0d", i), rf[i], model_rf[i]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
